fma_sched: RTL

Multi-requester scheduler that time-shares one pipelined single-precision FMA (`FMA_clk`) among `NREQ` clients. It runs a round-robin arbiter that issues at most one a·b+c operation per cycle into the FMA, and carries a valid/tag shadow pipeline alongside the datapath. When a result emerges it returns it to the issuing client. Per-client credit counters bound the number of outstanding operations. The block sits between client engines and the FMA instance, which has no valid or stall of its own.

---
 rtl/fma_sched_pkg.sv | 11 +
 rtl/fma_sched_rr_arbiter.sv | 28 ++
 rtl/fma_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fma_sched_pkg.sv
// Shared types and defaults for the FMA scheduler.
package fma_sched_pkg;

   localparam int unsigned FMA_LAT_DEFAULT = 5;
   localparam int unsigned NREQ_DEFAULT    = 4;
   localparam int unsigned MAX_OUT_DEFAULT = 4;

   typedef logic [31:0] fp32_t;
   typedef logic [$clog2(NREQ_DEFAULT)-1:0] req_id_t;

endpackage

// File: rtl/fma_sched_rr_arbiter.sv
// Combinational round-robin picker: first eligible client at or after rr_ptr.
module rr_arbiter
   import fma_sched_pkg::*;
#(
   parameter  int unsigned NREQ = NREQ_DEFAULT,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [IDW-1:0]  rr_ptr,
   output logic            grant_valid,
   output logic [IDW-1:0]  grant_id,
   output logic [NREQ-1:0] grant
);

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      grant       = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!grant_valid && eligible[IDW'((32'(rr_ptr) + k) % NREQ)]) begin
            grant_valid = 1'b1;
            grant_id    = IDW'((32'(rr_ptr) + k) % NREQ);
         end
      end
      if (grant_valid) grant[grant_id] = 1'b1;
   end

endmodule

// File: rtl/fma_sched.sv
// Time-shares one pipelined FMA among NREQ clients with round-robin issue,
// a valid/tag shadow pipeline matching the FMA latency, and per-client credits.
module fma_sched
   import fma_sched_pkg::*;
#(
   parameter int unsigned NREQ    = NREQ_DEFAULT,
   parameter int unsigned FMA_LAT = FMA_LAT_DEFAULT,
   parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   input  logic [NREQ*32-1:0]   req_c,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_data,
   output logic [31:0]          fma_a,
   output logic [31:0]          fma_b,
   output logic [31:0]          fma_c,
   input  logic [31:0]          fma_result,
   output logic                 busy
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] CREDIT_FULL = CW'(MAX_OUT);

   logic [CW-1:0]      credit_q [NREQ];
   logic [CW-1:0]      credit_d [NREQ];
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [FMA_LAT-1:0] vld_sr_q, vld_sr_d;
   logic [IDW-1:0]     id_sr_q [FMA_LAT];
   logic [IDW-1:0]     id_sr_d [FMA_LAT];

   logic [NREQ-1:0]    eligible;
   logic [NREQ-1:0]    grant;
   logic               grant_valid;
   logic [IDW-1:0]     grant_id;
   logic               rsp_hit;
   logic [IDW-1:0]     rsp_id;
   fp32_t              op_a, op_b, op_c;

   // Gating with rst_n keeps req_ready and the FMA operands at zero under reset.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         eligible[i] = rst_n && req_valid[i] && (credit_q[i] != '0);
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .eligible    (eligible),
      .rr_ptr      (rr_ptr_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .grant       (grant)
   );

   assign req_ready = grant;

   always_comb begin
      op_a = '0;
      op_b = '0;
      op_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            op_a = req_a[i*32 +: 32];
            op_b = req_b[i*32 +: 32];
            op_c = req_c[i*32 +: 32];
         end
      end
   end

   assign fma_a = op_a;
   assign fma_b = op_b;
   assign fma_c = op_c;

   assign rsp_hit = vld_sr_q[FMA_LAT-1];
   assign rsp_id  = id_sr_q[FMA_LAT-1];

   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (rsp_hit) begin
         rsp_valid[rsp_id] = 1'b1;
         rsp_data          = fma_result;
      end
   end

   always_comb begin
      busy = |vld_sr_q;
      for (int unsigned i = 0; i < NREQ; i++)
         if (credit_q[i] != CREDIT_FULL) busy = 1'b1;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_valid)
         rr_ptr_d = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);

      vld_sr_d    = '0;
      vld_sr_d[0] = grant_valid;
      id_sr_d[0]  = grant_id;
      for (int unsigned k = 1; k < FMA_LAT; k++) begin
         vld_sr_d[k] = vld_sr_q[k-1];
         id_sr_d[k]  = id_sr_q[k-1];
      end

      // Issue and response to the same client in one cycle cancel out.
      for (int unsigned i = 0; i < NREQ; i++) begin
         credit_d[i] = credit_q[i];
         if (rsp_valid[i] && !grant[i] && credit_q[i] != CREDIT_FULL)
            credit_d[i] = credit_q[i] + CW'(1);
         else if (grant[i] && !rsp_valid[i] && credit_q[i] != '0)
            credit_d[i] = credit_q[i] - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         vld_sr_q <= '0;
         for (int unsigned i = 0; i < NREQ; i++) credit_q[i] <= CREDIT_FULL;
         for (int unsigned k = 0; k < FMA_LAT; k++) id_sr_q[k] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         vld_sr_q <= vld_sr_d;
         credit_q <= credit_d;
         id_sr_q  <= id_sr_d;
      end
   end

endmodule
